// File: rtl/fp_core_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of the shared
// floating-point core.
package fp_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 35;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Width of a counter that must reach LATENCY.
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/fp_core_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above last_grant+1,
// wrapping around.
module rr_pick
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx
);

    logic found_s;
    int   cand_s;

    // Walk the requesters starting just after the last one served
    always_comb begin
        found_s     = 1'b0;
        cand_s      = 0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = (int'(last_grant) + k) % NUM_REQ;
            if (!found_s && req[cand_s]) begin
                found_s  = 1'b1;
                pick_idx = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        pick_onehot[pick_idx] = found_s;
        valid                 = found_s;
    end

endmodule

// File: rtl/fp_core_arbiter.sv
// Time-shares one multi-cycle floating-point core between NUM_REQ requesters;
// every operation gets the full LATENCY enabled cycles before capture.
module fp_core_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           result,
    output logic                  busy,
    output logic                  core_clk_en,
    output logic [31:0]           core_data,
    input  logic [31:0]           core_result
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(LATENCY);

    arb_state_t         state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] grant_r, done_r;
    logic [IDX_W-1:0]   grant_idx_r, last_grant_r;
    logic [31:0]        result_r, core_data_r;
    logic               busy_r, core_clk_en_r;

    logic               pick_valid_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               run_last_s;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req         (req),
        .last_grant  (last_grant_r),
        .valid       (pick_valid_s),
        .pick_onehot (pick_onehot_s),
        .pick_idx    (pick_idx_s)
    );

    assign run_last_s = (cnt_r == CNT_W'(LATENCY - 1));

    // Next-state decision
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register, cycle counter and all registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            grant_r       <= '0;
            grant_idx_r   <= '0;
            done_r        <= '0;
            busy_r        <= 1'b0;
            core_clk_en_r <= 1'b0;
            core_data_r   <= 32'h0000_0000;
            result_r      <= 32'h0000_0000;
            last_grant_r  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r       <= state_nx_s;
            busy_r        <= (state_nx_s != ST_IDLE);
            core_clk_en_r <= (state_nx_s == ST_RUN);
            done_r        <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r     <= pick_onehot_s;
                        grant_idx_r <= pick_idx_s;
                        core_data_r <= req_data[32*int'(pick_idx_s) +: 32];
                        cnt_r       <= '0;
                    end else begin
                        grant_r <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Core output is only trustworthy after the full latency
                    if (run_last_s) begin
                        result_r     <= core_result;
                        last_grant_r <= grant_idx_r;
                        done_r       <= grant_r;
                    end else begin
                        result_r <= result_r;
                    end
                end
                ST_DONE: grant_r <= '0;
                default: grant_r <= '0;
            endcase
        end
    end

    assign grant       = grant_r;
    assign done        = done_r;
    assign result      = result_r;
    assign busy        = busy_r;
    assign core_clk_en = core_clk_en_r;
    assign core_data   = core_data_r;

endmodule

// File: tb/tb_fp_core_arbiter.sv
// Scoreboard bench: a timing/arbitration model predicts each done pulse,
// a negedge monitor pops and compares; a small LATENCY=2 instance is checked directly.
module tb_fp_core_arbiter;

    localparam int N   = 4;
    localparam int LAT = 35;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset_n;
    logic [N-1:0]   req, grant, done;
    logic [32*N-1:0] req_data;
    logic [31:0]    result, core_data, core_result;
    logic           busy, core_clk_en;

    logic [1:0]  req2, grant2, done2;
    logic [63:0] req_data2;
    logic [31:0] result2, core_data2, core_result2;
    logic        busy2, core_clk_en2;

    fp_core_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .core_clk_en(core_clk_en), .core_data(core_data), .core_result(core_result)
    );

    fp_core_arbiter #(.NUM_REQ(2), .LATENCY(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .req(req2), .req_data(req_data2),
        .grant(grant2), .done(done2), .result(result2), .busy(busy2),
        .core_clk_en(core_clk_en2), .core_data(core_data2), .core_result(core_result2)
    );

    function automatic logic [31:0] core_f(input logic [31:0] x);
        if (x == 32'h3F80_0000) return 32'h3F57_6AA4;
        return {x[15:0], x[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // Shared-core model: output is garbage until LAT enabled cycles with stable data
    int          en_cnt = 0;
    logic [31:0] prev_data;
    always @(posedge clock) begin
        if (!core_clk_en) en_cnt <= 0;
        else if (en_cnt != 0 && core_data != prev_data) en_cnt <= 1;
        else en_cnt <= en_cnt + 1;
        prev_data <= core_data;
    end
    assign core_result  = (core_clk_en && en_cnt >= LAT - 1) ? core_f(core_data) : 32'hDEAD_BEEF;
    assign core_result2 = core_data2 ^ 32'h0F0F_0F0F;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] res;
        int          dcyc;
    } exp_t;
    exp_t sbq[$];

    int  done_at[N];
    int  idle_from;
    int  last_g;
    bit  random_mode = 1'b0;
    bit  renew_all   = 1'b0;

    task automatic set_data(input int i, input logic [31:0] w);
        req_data[32*i +: 32] = w;
    endtask

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 3) == 0) return 32'h3F80_0000;
        return $urandom;
    endfunction

    // Arbiter model: when free, serve the next requester after last_g, wrapping
    task automatic model_pick();
        int i;
        exp_t e;
        if (cycle >= idle_from) begin
            for (int k = 1; k <= N; k++) begin
                i = (last_g + k) % N;
                if (req[i]) begin
                    e.idx  = i;
                    e.res  = core_f(req_data[32*i +: 32]);
                    e.dcyc = cycle + LAT + 1;
                    sbq.push_back(e);
                    done_at[i] = e.dcyc;
                    idle_from  = cycle + LAT + 2;
                    last_g     = i;
                    break;
                end
            end
        end
    endtask

    task automatic raise(input logic [N-1:0] mask, input logic [31:0] w);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req[i] = 1'b1;
                set_data(i, w ^ 32'(i));
                done_at[i] = -1;
            end
        end
        model_pick();
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req[i] && done_at[i] >= 0 && cycle == done_at[i] + 1) begin
                done_at[i] = -1;
                if (renew_all || (random_mode && $urandom_range(0, 1) == 1)) set_data(i, rand_word());
                else req[i] = 1'b0;
            end else if (req[i] && done_at[i] >= 0 && random_mode && $urandom_range(0, 7) == 0) begin
                set_data(i, $urandom);
            end else if (!req[i] && random_mode && $urandom_range(0, 5) == 0) begin
                req[i] = 1'b1;
                set_data(i, rand_word());
            end
        end
        model_pick();
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while ((req != '0 || sbq.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: still busy after %0d cycles, queue %0d", maxc, sbq.size());
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        sbq.delete();
        req = '0;
        req2 = '0;
        for (int i = 0; i < N; i++) done_at[i] = -1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_clk_en", 32'(core_clk_en), 32'h0);
        chk("rst_core_data", core_data, 32'h0);
        chk("rst_result", result, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset_n   = 1'b1;
        last_g    = N - 1;
        idle_from = cycle;
    endtask

    // Monitor: every done pulse must match the oldest predicted completion
    int en_run = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() != 0 && sbq[0].dcyc < cycle) begin
                e = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL done_missing: requester %0d expected done at cycle %0d, pulse absent", e.idx, e.dcyc);
            end
            if (done !== '0) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=%b at cycle %0d, expected none", done, cycle);
                end else begin
                    e = sbq.pop_front();
                    chk("done_onehot", 32'(done), 32'(1) << e.idx);
                    chk("done_grant", 32'(grant), 32'(1) << e.idx);
                    chk("done_result", result, e.res);
                    chk("done_cycle", 32'(cycle), 32'(e.dcyc));
                    chk("clk_en_cycles", 32'(en_run), 32'(LAT));
                    chk("clk_en_off_in_done", 32'(core_clk_en), 32'h0);
                end
            end
            if (core_clk_en) en_run++;
            else en_run = 0;
        end
    end

    initial begin
        req = '0; req_data = '0; req2 = '0; req_data2 = '0;
        do_reset();

        // Single request on requester 0
        raise(4'b0001, 32'h3F80_0000);
        run_until_idle(100);

        // Serve 2, then 1 and 2 together: search wraps through 3 and 0 to 1
        raise(4'b0100, 32'h4049_0FDB);
        run_until_idle(100);
        raise(4'b0110, 32'hC000_0000);
        run_until_idle(200);

        // Operand change mid-operation must not reach the core
        raise(4'b0001, 32'h4000_0000);
        repeat (10) step();
        set_data(0, 32'h0000_0000);
        while (done_at[0] >= 0 && cycle <= done_at[0]) begin
            chk("core_data_held", core_data, 32'h4000_0000);
            step();
        end
        run_until_idle(100);

        // Reset in the middle of RUN aborts silently; next request runs normally
        raise(4'b0001, $urandom);
        repeat (20) step();
        do_reset();
        raise(4'b1000, 32'h3F80_0000);
        run_until_idle(100);

        // All four requesting continuously from reset
        do_reset();
        renew_all = 1'b1;
        raise(4'b1111, 32'h4110_0000);
        repeat (5 * (LAT + 2)) step();
        renew_all = 1'b0;
        run_until_idle(400);

        // Randomized traffic
        random_mode = 1'b1;
        repeat (3000) step();
        random_mode = 1'b0;
        run_until_idle(400);

        // LATENCY=2 instance: RUN in cycles 1-2, done in 3, IDLE in 4
        req2 = 2'b01;
        req_data2 = {32'hFFFF_FFFF, 32'h1234_5678};
        @(posedge clock); #1;
        chk("l2_c1_busy", 32'(busy2), 32'h1);
        chk("l2_c1_clk_en", 32'(core_clk_en2), 32'h1);
        chk("l2_c1_grant", 32'(grant2), 32'h1);
        chk("l2_c1_core_data", core_data2, 32'h1234_5678);
        @(posedge clock); #1;
        chk("l2_c2_clk_en", 32'(core_clk_en2), 32'h1);
        chk("l2_c2_done", 32'(done2), 32'h0);
        @(posedge clock); #1;
        chk("l2_c3_done", 32'(done2), 32'h1);
        chk("l2_c3_clk_en", 32'(core_clk_en2), 32'h0);
        chk("l2_c3_result", result2, 32'h1234_5678 ^ 32'h0F0F_0F0F);
        req2 = 2'b00;
        @(posedge clock); #1;
        chk("l2_c4_busy", 32'(busy2), 32'h0);
        chk("l2_c4_grant", 32'(grant2), 32'h0);
        chk("l2_c4_done", 32'(done2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
